// File: rtl/seq_detector_param.sv
// seq_detector_param
//
// Serial bit-stream pattern detector with a run-time loadable pattern of PAT_W
// bits. Input bits are qualified by x_valid, so the stream may contain gaps.
// The first bit received is the MSB of the pattern. After the edge that samples
// the completing bit, y pulses high for one cycle. Overlapping or
// non-overlapping detection is selected per sample by ovl. A saturating counter
// tracks the number of matches.
//
// Parameters:
//   PAT_W     pattern length in bits (2..16)
//   PAT_RST   pattern held after reset
//   CNT_W     width of the match counter
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   x_valid    x is sampled on this edge when high
//   x          serial data bit, pattern MSB first
//   load       latch pattern into the pattern register; discards history
//   pattern    new pattern, sampled when load is high
//   ovl        1 = overlapping detection, 0 = non-overlapping
//   clear_cnt  synchronous clear of match_cnt (wins over a coincident hit)
//   y          registered one-cycle match pulse
//   match_cnt  saturating match count

module seq_detector_param #(
   parameter int unsigned      PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011),
   parameter int unsigned      CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x_valid,
   input  logic             x,
   input  logic             load,
   input  logic [PAT_W-1:0] pattern,
   input  logic             ovl,
   input  logic             clear_cnt,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   // State
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [PAT_W-1:0]  shreg_q, shreg_d;   // newest bit in bit 0
   logic [FILL_W-1:0] fill_q, fill_d;     // valid bits in shreg, saturates at PAT_W
   logic              y_q, y_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Candidate history if the current bit is accepted
   logic [PAT_W-1:0]  shreg_n;
   logic [FILL_W-1:0] fill_n;
   logic              hit;

   always_comb begin
      shreg_n = {shreg_q[PAT_W-2:0], x};
      fill_n  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      // The fill qualifier keeps the zero-initialised shreg from matching an
      // all-zero pattern before PAT_W real bits have arrived.
      hit     = x_valid && !load && (fill_n == FILL_FULL) && (shreg_n == pat_q);
   end

   // Next-state for the detector history and pulse
   always_comb begin
      pat_d   = pat_q;
      shreg_d = shreg_q;
      fill_d  = fill_q;
      y_d     = 1'b0;

      if (load) begin
         pat_d   = pattern;
         shreg_d = '0;
         fill_d  = '0;
      end else if (x_valid) begin
         shreg_d = shreg_n;
         if (hit) begin
            y_d    = 1'b1;
            // Non-overlapping: restarting fill forces PAT_W fresh bits, which
            // fully overwrite shreg before the next possible hit.
            fill_d = ovl ? fill_n : '0;
         end else begin
            fill_d = fill_n;
         end
      end
   end

   // Match counter: clear wins over a coincident hit, no wrap at the top
   always_comb begin
      cnt_d = cnt_q;
      if (clear_cnt) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q   <= PAT_RST;
         shreg_q <= '0;
         fill_q  <= '0;
         y_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         shreg_q <= shreg_d;
         fill_q  <= fill_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
      end
   end

   assign y         = y_q;
   assign match_cnt = cnt_q;

endmodule
